// File: rtl/mesh_term_src_fifo_if.sv
// Push/pop bundle between the terminal, the source FIFO and the mesh router terminal port.
// Signal names match the router-facing convention (push/popin/pndng_i_in/data_out_i_in).
interface mesh_term_src_fifo_if #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 16
);
    localparam int CNT_W = $clog2(fifo_depth + 1);

    logic               push;
    logic [pckg_sz-1:0] data_in;
    logic               full;
    logic               popin;
    logic               pndng_i_in;
    logic [pckg_sz-1:0] data_out_i_in;
    logic [CNT_W-1:0]   count;
    logic               ovf;
    logic               udf;
    logic [7:0]         drop_cnt;

    modport master (
        output push, data_in, popin,
        input  full, pndng_i_in, data_out_i_in, count, ovf, udf, drop_cnt
    );

    modport slave (
        input  push, data_in, popin,
        output full, pndng_i_in, data_out_i_in, count, ovf, udf, drop_cnt
    );
endinterface

// File: rtl/mesh_term_src_fifo.sv
// Per-terminal first-word-fall-through source buffer feeding a mesh router terminal port.
// Optional saturating dropped-push counter enabled by defining MESH_SRC_DROP_CNT_EN.
module mesh_term_src_fifo #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 16,
    localparam int CNT_W     = $clog2(fifo_depth + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    mesh_term_src_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(fifo_depth);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(fifo_depth - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(fifo_depth);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic               wr_en_s;
    logic               rd_en_s;
    logic [pckg_sz-1:0] mem [fifo_depth];

    // Occupancy FSM: decide which side of the FIFO moves and record sticky errors.
    always_comb begin
        wr_en_s = 1'b0;
        rd_en_s = 1'b0;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        case (state_q)
            ST_EMPTY: begin
                // A pop against an empty buffer is an underflow even when a push lands the same cycle.
                wr_en_s = bus.push;
                if (bus.popin) begin
                    udf_d = 1'b1;
                end else begin
                    udf_d = udf_q;
                end
            end
            ST_PARTIAL: begin
                wr_en_s = bus.push;
                rd_en_s = bus.popin;
            end
            ST_FULL: begin
                rd_en_s = bus.popin;
                wr_en_s = bus.push & bus.popin;
                if (bus.push && !bus.popin) begin
                    ovf_d = 1'b1;
                end else begin
                    ovf_d = ovf_q;
                end
            end
            default: begin
                wr_en_s = 1'b0;
                rd_en_s = 1'b0;
            end
        endcase

        if (wr_en_s && !rd_en_s) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_en_s && !wr_en_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end

        if (count_d == CNT_ZERO) begin
            state_d = ST_EMPTY;
        end else if (count_d == CNT_FULL) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_PARTIAL;
        end
    end

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? PTR_ZERO : (wr_ptr_q + PTR_ONE);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? PTR_ZERO : (rd_ptr_q + PTR_ONE);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Control state register; reset discards all queued entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_EMPTY;
            rd_ptr_q <= PTR_ZERO;
            wr_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Packet storage; contents survive reset and are masked by the EMPTY state.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_ptr_q] <= bus.data_in;
        end
    end

`ifdef MESH_SRC_DROP_CNT_EN
    logic       drop_inc_s;
    logic [7:0] drop_cnt_q;

    assign drop_inc_s = bus.push & ~bus.popin & (state_q == ST_FULL);

    // Saturating count of pushes discarded while full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= 8'd0;
        end else if (drop_inc_s && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_q <= drop_cnt_q;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`else
    assign bus.drop_cnt = 8'd0;
`endif

    assign bus.full          = (state_q == ST_FULL);
    assign bus.pndng_i_in    = (state_q != ST_EMPTY);
    assign bus.data_out_i_in = (state_q != ST_EMPTY) ? mem[rd_ptr_q] : {pckg_sz{1'b0}};
    assign bus.count         = count_q;
    assign bus.ovf           = ovf_q;
    assign bus.udf           = udf_q;

endmodule

// File: doc/mesh_term_src_fifo.md
Name: mesh_term_src_fifo

Overview:
- Per-terminal source buffer that sits directly upstream of a mesh router terminal port.
- Accepts packets from the terminal (agent/driver side) on a push interface.
- Stores them in a first-word-fall-through FIFO.
- Presents the head packet to the mesh as data_out_i_in/pndng_i_in; the mesh consumes it with popin.
- One instance per terminal; ROWS*COLUMS instances in total.

Parameters:
pckg_sz, 40, packet width in bits (header plus payload, passed through unmodified)
fifo_depth, 16, number of packet entries; any value >= 2, not restricted to powers of two
CNT_W, $clog2(fifo_depth+1), width of occupancy count (derived; not overridden)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately)
push  input  1  terminal writes data_in this cycle
data_in  input  pckg_sz  packet from terminal
full  output  1  FIFO holds fifo_depth entries
popin  input  1  mesh consumes head packet this cycle
pndng_i_in  output  1  FIFO non-empty; head packet valid
data_out_i_in  output  pckg_sz  head packet (FWFT)
count  output  CNT_W  current occupancy
ovf  output  1  sticky: push was dropped while full
udf  output  1  sticky: popin while empty
drop_cnt  output  8  dropped-push counter (see Optional Feature)

Behaviour:
- Reset (reset==0, asynchronous):
  - rd_ptr=0, wr_ptr=0, count=0.
  - full=0, pndng_i_in=0, ovf=0, udf=0, drop_cnt=0.
  - data_out_i_in=0.
  - Storage array contents are not cleared.
- Reset release: state machine starts in EMPTY on the first rising edge with reset==1.
- Occupancy states: EMPTY (count==0), PARTIAL (0<count<fifo_depth), FULL (count==fifo_depth).
  - pndng_i_in = (state!=EMPTY); full = (state==FULL). Both are registered-state-derived with no combinational path from push/popin.
- data_out_i_in = mem[rd_ptr] while pndng_i_in==1; forced to 0 while EMPTY.
- Latency:
  - Push into EMPTY: pndng_i_in rises and data_out_i_in is valid on the next cycle.
  - Pop: the next entry appears on the cycle after popin.
- Pointer wrap: a pointer increments to fifo_depth-1, then returns to 0. Explicit compare; no reliance on power-of-two overflow.
- push && !popin:
  - Not FULL: write mem[wr_ptr], wr_ptr++, count++.
  - FULL: write ignored; ovf<=1; drop_cnt increments.
- popin && !push:
  - Not EMPTY: rd_ptr++, count--.
  - EMPTY: ignored; udf<=1.
- push && popin:
  - PARTIAL: both performed; count unchanged.
  - FULL: both accepted (pop frees the slot); count stays fifo_depth; no ovf.
  - EMPTY: push accepted, pop treated as underflow (udf<=1); count becomes 1. No bypass: data is not forwarded in the same cycle.
- ovf and udf clear only on reset.
- data_in is passed bit-exact; the block never inspects or modifies header fields.
- Reset asserted mid-transfer: all in-flight entries are discarded; pndng_i_in falls immediately (asynchronously).

Optional Feature:
- Macro: MESH_SRC_DROP_CNT_EN.
- Defined:
  - drop_cnt is an 8-bit counter incremented on every dropped push (push while FULL without popin).
  - Saturates at 255; cleared only by reset.
- Not defined:
  - Counter logic is omitted and drop_cnt is tied to 0.
  - ovf still behaves as specified.

Test Plan:
1. Reset then push 0x00_0000_0001 -> next cycle pndng_i_in=1, data_out_i_in=0x00_0000_0001, count=1; popin one cycle -> pndng_i_in=0, count=0, data_out_i_in=0.
2. Push 16 packets 0x1..0x10 with no popin -> full=1, count=16. 17th push 0xFF -> ovf=1, drop_cnt=1 (macro on) or 0 (macro off). Then 16 pops return 0x1..0x10 in order.
3. Fill to 16, then push 0x20 and popin in the same cycle -> count stays 16, ovf=0. The output order continues 0x2..0x10, then 0x20 (wrap path exercised).
4. popin on EMPTY -> udf=1, count=0, pndng_i_in=0. Simultaneous push 0x5 and popin on EMPTY -> count=1, head=0x5, udf=1.
5. Push 8 packets, then drive reset=0 mid-cycle (asynchronously) -> count=0, pndng_i_in=0, ovf=0 immediately without waiting for a clock edge. After release, a push of 0xAB appears as the head.
6. Macro on: 300 pushes while FULL with no popin -> drop_cnt saturates at 255.
